// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron and its byte-serial parameter loader.
// Optional macro PARAM_CHECKSUM_EN adds the GET_CHK state (3-byte packets).
package lif_pkg;

    localparam int WEIGHT_W = 3;
    localparam int LEAK_W   = 2;
    localparam int THR_W    = 8;

    // B0 = {weight, leak_config, reserved}
    localparam int WEIGHT_MSB = 7;
    localparam int WEIGHT_LSB = 5;
    localparam int LEAK_MSB   = 4;
    localparam int LEAK_LSB   = 3;
    localparam int RSVD_MSB   = 2;
    localparam int RSVD_LSB   = 0;

    localparam logic [7:0] CHK_SEED = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GET_CFG = 2'd1,
`ifdef PARAM_CHECKSUM_EN
        ST_GET_THR = 2'd2,
        ST_GET_CHK = 2'd3
`else
        ST_GET_THR = 2'd2
`endif
    } lif_state_e;

endpackage

// File: rtl/lif_byte_timeout.sv
// Inter-byte idle counter: counts enabled cycles, clears on demand, and
// flags expiry on the cycle whose increment would reach LIMIT.
module lif_byte_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [7:0] LIMIT_M1 = 8'(LIMIT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 8'd1;
    end

    assign expire = en && (cnt == LIMIT_M1);

endmodule

// File: rtl/lif_param_loader.sv
// Byte-serial LIF parameter loader: shadows a framed packet and commits
// weight/leak/threshold atomically. PARAM_CHECKSUM_EN adds a B2 check byte.
module lif_param_loader
    import lif_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [7:0] THR_RESET      = 8'hFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_start,
    input  logic [7:0]          data_in,
    input  logic                data_valid,
    output logic [WEIGHT_W-1:0] weight,
    output logic [LEAK_W-1:0]   leak_config,
    output logic [THR_W-1:0]    threshold,
    output logic                params_ready,
    output logic                busy,
    output logic                load_err
);

    lif_state_e state;
    logic [WEIGHT_W+LEAK_W-1:0] cfg_sh;
`ifdef PARAM_CHECKSUM_EN
    logic [THR_W-1:0] thr_sh;
    logic [7:0]       chk_exp;
`endif
    logic tmo_en, tmo_clr, tmo_exp;

    assign busy = (state != ST_IDLE);

    // load_start outranks data_valid; any byte seen while busy resets the timer
    assign tmo_en  = busy && !load_start && !data_valid;
    assign tmo_clr = !busy || load_start || data_valid;

    lif_byte_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_exp)
    );

`ifdef PARAM_CHECKSUM_EN
    assign chk_exp = {cfg_sh, 3'b000} ^ thr_sh ^ CHK_SEED;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cfg_sh       <= '0;
`ifdef PARAM_CHECKSUM_EN
            thr_sh       <= '0;
`endif
            weight       <= '0;
            leak_config  <= '0;
            threshold    <= THR_RESET;
            params_ready <= 1'b0;
            load_err     <= 1'b0;
        end else if (load_start) begin
            state        <= ST_GET_CFG;
            cfg_sh       <= '0;
`ifdef PARAM_CHECKSUM_EN
            thr_sh       <= '0;
`endif
            params_ready <= 1'b0;
            load_err     <= 1'b0;
        end else if (busy) begin
            if (tmo_exp) begin
                state    <= ST_IDLE;
                load_err <= 1'b1;
            end else if (data_valid) begin
                case (state)
                    ST_GET_CFG: begin
                        if (data_in[RSVD_MSB:RSVD_LSB] != '0) begin
                            state    <= ST_IDLE;
                            load_err <= 1'b1;
                        end else begin
                            cfg_sh <= data_in[WEIGHT_MSB:LEAK_LSB];
                            state  <= ST_GET_THR;
                        end
                    end
`ifdef PARAM_CHECKSUM_EN
                    ST_GET_THR: begin
                        thr_sh <= data_in;
                        state  <= ST_GET_CHK;
                    end
                    ST_GET_CHK: begin
                        state <= ST_IDLE;
                        if (data_in == chk_exp) begin
                            weight       <= cfg_sh[WEIGHT_MSB-LEAK_LSB:WEIGHT_LSB-LEAK_LSB];
                            leak_config  <= cfg_sh[LEAK_MSB-LEAK_LSB:0];
                            threshold    <= thr_sh;
                            params_ready <= 1'b1;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
`else
                    ST_GET_THR: begin
                        state        <= ST_IDLE;
                        weight       <= cfg_sh[WEIGHT_MSB-LEAK_LSB:WEIGHT_LSB-LEAK_LSB];
                        leak_config  <= cfg_sh[LEAK_MSB-LEAK_LSB:0];
                        threshold    <= data_in;
                        params_ready <= 1'b1;
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
